// File: rtl/frame_seq_pkg.sv
// ----------------------------------------------------------------------------
// frame_seq_pkg
//   Shared types and constants for the frame update sequencer.
//   - seq_state_t : sequencer FSM states (IDLE, ISSUE, WAIT)
//   - PH_*        : phase indices of the game-logic update blocks, in issue order
//   - FRAME_CNT_W : width of the vsync edge counter
// ----------------------------------------------------------------------------
package frame_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

  localparam int PH_PADDLE = 0;
  localparam int PH_BALL   = 1;
  localparam int PH_BRICK  = 2;
  localparam int PH_SCORE  = 3;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/frame_update_sequencer_if.sv
// ----------------------------------------------------------------------------
// frame_update_sequencer_if
//   Start/done handshake between the sequencer and the game-logic blocks.
//   phase_start  : one-hot, one-cycle start pulse per phase (sequencer -> blocks)
//   phase_done   : per-phase completion pulse/level           (blocks -> sequencer)
//   phase_active : index of the phase currently issued/awaited
//   busy         : a sequence is in progress
//   frame_tick   : one-cycle pulse when a full sequence completes
//   Modports: master = sequencer side, slave = game-logic side.
// ----------------------------------------------------------------------------
interface frame_update_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int PHASE_W    = 2
);

  logic [NUM_PHASES-1:0] phase_start;
  logic [NUM_PHASES-1:0] phase_done;
  logic [PHASE_W-1:0]    phase_active;
  logic                  busy;
  logic                  frame_tick;

  modport master (
    output phase_start,
    output phase_active,
    output busy,
    output frame_tick,
    input  phase_done
  );

  modport slave (
    input  phase_start,
    input  phase_active,
    input  busy,
    input  frame_tick,
    output phase_done
  );

endinterface

// File: rtl/seq_timeout_counter.sv
// ----------------------------------------------------------------------------
// seq_timeout_counter
//   Per-phase wait counter. Cleared while a phase is being issued, counts each
//   cycle spent waiting, and flags expiry on the cycle the count reaches
//   TIMEOUT-1 while still waiting.
//   clkgen  in  clock
//   rst_n   in  asynchronous active-low reset
//   clear   in  reset the count to 0
//   enable  in  count this cycle (sequencer is waiting for done)
//   expired out waiting and count == TIMEOUT-1
// ----------------------------------------------------------------------------
module seq_timeout_counter #(
  parameter int TIMEOUT = 4096
) (
  input  logic clkgen,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so a held enable can never wrap back to a small count.
  always_ff @(posedge clkgen or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/frame_update_sequencer.sv
// ----------------------------------------------------------------------------
// frame_update_sequencer
//   Runs the per-frame game-state update phases strictly in order during
//   vertical blanking. A vsync rising edge (every FRAME_DIV-th one) starts a
//   sequence; each phase gets a one-cycle start pulse and is then awaited until
//   its done bit or a timeout, after which the next phase is issued.
//   clkgen        in  pixel clock
//   rst_n         in  asynchronous active-low reset
//   vsync         in  active-high vsync from the timing generator
//   run           in  1 = allow new sequences, 0 = pause (frames still counted)
//   err_clr       in  clears timeout_err, timeout_phase and overrun
//   seq_if        master modport: phase_start/phase_done/phase_active/busy/frame_tick
//   frame_count   out vsync rising edges since reset (wraps)
//   timeout_err   out sticky: some phase timed out
//   timeout_phase out index of the most recent timed-out phase
//   overrun       out sticky: vsync edge arrived while a sequence was running
// ----------------------------------------------------------------------------
module frame_update_sequencer
  import frame_seq_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int TIMEOUT    = 4096,
  parameter int FRAME_DIV  = 1,
  parameter int PHASE_W    = 2
) (
  input  logic                   clkgen,
  input  logic                   rst_n,
  input  logic                   vsync,
  input  logic                   run,
  input  logic                   err_clr,
  frame_update_sequencer_if.master seq_if,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   timeout_err,
  output logic [PHASE_W-1:0]     timeout_phase,
  output logic                   overrun
);

  localparam int                 DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [PHASE_W-1:0] IDX_LAST = PHASE_W'(NUM_PHASES - 1);

  seq_state_t         state, next_state;
  logic [PHASE_W-1:0] idx, next_idx;
  logic               vsync_q;
  logic               vs_edge;
  logic [DIV_W-1:0]   div_cnt;
  logic               eligible;
  logic               tick_next;
  logic               timeout_hit;
  logic               wait_expired;
  logic               done_cur;

  assign vs_edge  = vsync & ~vsync_q;
  assign eligible = vs_edge && (div_cnt == '0);
  assign done_cur = seq_if.phase_done[idx];

  seq_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clkgen  (clkgen),
    .rst_n   (rst_n),
    .clear   (state == ISSUE),
    .enable  (state == WAIT),
    .expired (wait_expired)
  );

  // Edge detector, frame counter and divider see every edge, whether or not a
  // sequence is started for it.
  always_ff @(posedge clkgen or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      frame_count <= '0;
      div_cnt     <= '0;
    end else begin
      vsync_q <= vsync;
      if (vs_edge) begin
        frame_count <= frame_count + FRAME_CNT_W'(1);
        div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clkgen or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      seq_if.frame_tick <= 1'b0;
    end else begin
      state      <= next_state;
      idx        <= next_idx;
      seq_if.frame_tick <= tick_next;
    end
  end

  // Done has priority over the timeout, so a done arriving on the expiry
  // cycle advances cleanly without raising an error.
  always_comb begin
    next_state  = state;
    next_idx    = idx;
    tick_next   = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (eligible && run) begin
          next_state = ISSUE;
          next_idx   = '0;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (done_cur || wait_expired) begin
          timeout_hit = !done_cur;
          if (idx == IDX_LAST) begin
            next_state = IDLE;
            tick_next  = 1'b1;
          end else begin
            next_state = ISSUE;
            next_idx   = idx + PHASE_W'(1);
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Sticky flags: a new error in the same cycle as err_clr stays set.
  always_ff @(posedge clkgen or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err   <= 1'b0;
      timeout_phase <= '0;
      overrun       <= 1'b0;
    end else begin
      if (err_clr) begin
        timeout_err   <= 1'b0;
        timeout_phase <= '0;
        overrun       <= 1'b0;
      end
      if (timeout_hit) begin
        timeout_err   <= 1'b1;
        timeout_phase <= idx;
      end
      if (vs_edge && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  assign seq_if.phase_start  = (state == ISSUE) ? (NUM_PHASES'(1) << idx) : '0;
  assign seq_if.phase_active = idx;
  assign seq_if.busy         = (state != IDLE);

endmodule

// File: tb/tb_frame_update_sequencer.sv
// ----------------------------------------------------------------------------
// tb_frame_update_sequencer
//   Self-checking bench. Instance A (TIMEOUT=16, FRAME_DIV=1) is driven from a
//   table of per-phase done delays; expected start pulses and frame ticks are
//   pushed to a scoreboard when vsync is driven and popped as the DUT emits
//   them. Instance B (FRAME_DIV=3, done always high) checks the frame divider
//   and run gating from a second table.
// ----------------------------------------------------------------------------
module tb_frame_update_sequencer;
  import frame_seq_pkg::*;

  localparam int NP = 4;
  localparam int PW = 2;
  localparam int TO = 16;

  logic clkgen = 1'b0;
  always #5 clkgen = ~clkgen;

  // Instance A
  logic          rst_n_a, vsync_a, run_a, err_clr_a;
  logic [15:0]   fc_a;
  logic          terr_a, ovr_a;
  logic [PW-1:0] tph_a;
  frame_update_sequencer_if #(.NUM_PHASES(NP), .PHASE_W(PW)) a_if ();

  frame_update_sequencer #(
    .NUM_PHASES (NP), .TIMEOUT (TO), .FRAME_DIV (1), .PHASE_W (PW)
  ) dut_a (
    .clkgen        (clkgen),
    .rst_n         (rst_n_a),
    .vsync         (vsync_a),
    .run           (run_a),
    .err_clr       (err_clr_a),
    .seq_if        (a_if),
    .frame_count   (fc_a),
    .timeout_err   (terr_a),
    .timeout_phase (tph_a),
    .overrun       (ovr_a)
  );

  // Instance B
  logic          rst_n_b, vsync_b, run_b, err_clr_b;
  logic [15:0]   fc_b;
  logic          terr_b, ovr_b;
  logic [PW-1:0] tph_b;
  frame_update_sequencer_if #(.NUM_PHASES(NP), .PHASE_W(PW)) b_if ();

  frame_update_sequencer #(
    .NUM_PHASES (NP), .TIMEOUT (TO), .FRAME_DIV (3), .PHASE_W (PW)
  ) dut_b (
    .clkgen        (clkgen),
    .rst_n         (rst_n_b),
    .vsync         (vsync_b),
    .run           (run_b),
    .err_clr       (err_clr_b),
    .seq_if        (b_if),
    .frame_count   (fc_b),
    .timeout_err   (terr_b),
    .timeout_phase (tph_b),
    .overrun       (ovr_b)
  );

  typedef struct {
    int            cyc;
    logic [NP-1:0] start;
    logic          tick;
  } ev_t;

  typedef struct {
    int            delay [NP];
    logic          exp_err;
    logic [PW-1:0] exp_tph;
    int            tick_ofs;
  } vec_t;

  typedef struct {
    logic rst_first;
    logic run;
    logic exp_seq;
  } div_vec_t;

  ev_t           sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            delay_cfg [NP];
  int            rem [NP];
  logic [NP-1:0] done_force;
  int            tick_cnt_a = 0;
  int            tick_cnt_b = 0;
  int            exp_fc_a = 0;
  int            exp_fc_b = 0;

  always @(posedge clkgen) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor and game-block model for instance A: each started phase
  // raises its done bit delay_cfg[i] cycles later (<=0 means never).
  always @(negedge clkgen) begin
    logic [NP-1:0] done_v;
    if (!rst_n_a) begin
      for (int i = 0; i < NP; i++) rem[i] = 0;
      a_if.phase_done = '0;
    end else begin
      if ((a_if.phase_start != '0) || a_if.frame_tick) begin
        if (a_if.frame_tick) tick_cnt_a++;
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_event", {27'd0, 32'(cyc), a_if.phase_start, a_if.frame_tick},
                      64'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          checkOutput("sb_event{cyc,start,tick}",
                      {27'd0, 32'(cyc), a_if.phase_start, a_if.frame_tick},
                      {27'd0, 32'(e.cyc), e.start, e.tick});
        end
      end
      done_v = '0;
      for (int i = 0; i < NP; i++) begin
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) done_v[i] = 1'b1;
        end
        if (a_if.phase_start[i] && (delay_cfg[i] > 0)) rem[i] = delay_cfg[i];
      end
      a_if.phase_done = done_v | done_force;
    end
  end

  always @(negedge clkgen) begin
    if (rst_n_b && b_if.frame_tick) tick_cnt_b++;
  end

  function automatic vec_t mkVec(input int d0, input int d1, input int d2, input int d3,
                                 input logic err, input logic [PW-1:0] tph, input int tofs);
    vec_t v;
    v.delay[0] = d0;
    v.delay[1] = d1;
    v.delay[2] = d2;
    v.delay[3] = d3;
    v.exp_err  = err;
    v.exp_tph  = tph;
    v.tick_ofs = tofs;
    return v;
  endfunction

  // Drives one vsync edge on A and pushes the expected start/tick events.
  task automatic applyStimulus(input vec_t v, output int k);
    int            t;
    logic [NP-1:0] s;
    @(negedge clkgen);
    for (int i = 0; i < NP; i++) delay_cfg[i] = v.delay[i];
    k = cyc;
    vsync_a = 1'b1;
    exp_fc_a++;
    t = k + 1;
    for (int i = 0; i < NP; i++) begin
      s = '0;
      s[i] = 1'b1;
      sb.push_back('{cyc: t, start: s, tick: 1'b0});
      t += ((v.delay[i] > 0) && (v.delay[i] <= TO)) ? v.delay[i] + 1 : TO + 1;
    end
    sb.push_back('{cyc: k + v.tick_ofs, start: '0, tick: 1'b1});
    repeat (2) @(negedge clkgen);
    vsync_a = 1'b0;
  endtask

  task automatic drainScoreboard(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0) && (n < budget)) begin
      @(negedge clkgen);
      n++;
    end
    checkOutput("sb_drain_left", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic pulseErrClr();
    @(negedge clkgen);
    err_clr_a = 1'b1;
    @(negedge clkgen);
    err_clr_a = 1'b0;
  endtask

  initial begin
    vec_t     vecs [7];
    div_vec_t dv [14];
    int       k;
    int       ticks0;

    // Delays per phase, expected error/phase, cycles from edge to frame_tick.
    vecs[0] = mkVec( 3,  3,  3,  3, 1'b0, 2'd0, 17);
    vecs[1] = mkVec( 3, -1,  3,  3, 1'b1, 2'd1, 30);
    vecs[2] = mkVec( 1,  1,  1,  1, 1'b0, 2'd0,  9);
    vecs[3] = mkVec( 2, 16,  5,  1, 1'b0, 2'd0, 29);
    vecs[4] = mkVec(-1, -1, -1, -1, 1'b1, 2'd3, 69);
    vecs[5] = mkVec( 7,  2, -1,  4, 1'b1, 2'd2, 34);
    vecs[6] = mkVec( 3,  1,  3,  3, 1'b0, 2'd0, 15);

    dv[0]  = '{1'b1, 1'b1, 1'b1};
    dv[1]  = '{1'b0, 1'b1, 1'b0};
    dv[2]  = '{1'b0, 1'b1, 1'b0};
    dv[3]  = '{1'b0, 1'b1, 1'b1};
    dv[4]  = '{1'b0, 1'b1, 1'b0};
    dv[5]  = '{1'b0, 1'b1, 1'b0};
    dv[6]  = '{1'b0, 1'b1, 1'b1};
    dv[7]  = '{1'b1, 1'b1, 1'b1};
    dv[8]  = '{1'b0, 1'b1, 1'b0};
    dv[9]  = '{1'b0, 1'b1, 1'b0};
    dv[10] = '{1'b0, 1'b0, 1'b0};
    dv[11] = '{1'b0, 1'b1, 1'b0};
    dv[12] = '{1'b0, 1'b1, 1'b0};
    dv[13] = '{1'b0, 1'b1, 1'b1};

    rst_n_a = 1'b0; vsync_a = 1'b0; run_a = 1'b1; err_clr_a = 1'b0;
    rst_n_b = 1'b0; vsync_b = 1'b0; run_b = 1'b1; err_clr_b = 1'b0;
    done_force = '0;
    b_if.phase_done = '1;
    for (int i = 0; i < NP; i++) delay_cfg[i] = 0;

    repeat (3) @(negedge clkgen);
    #1;
    checkOutput("rst_phase_start", 64'(a_if.phase_start), 64'd0);
    checkOutput("rst_busy", 64'(a_if.busy), 64'd0);
    checkOutput("rst_frame_tick", 64'(a_if.frame_tick), 64'd0);
    checkOutput("rst_phase_active", 64'(a_if.phase_active), 64'd0);
    checkOutput("rst_frame_count", 64'(fc_a), 64'd0);
    checkOutput("rst_timeout_err", 64'(terr_a), 64'd0);
    checkOutput("rst_overrun", 64'(ovr_a), 64'd0);

    @(negedge clkgen);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    repeat (3) @(negedge clkgen);

    // Table-driven sequences on A; the last entry holds done[1] from phase 0.
    for (int r = 0; r < 7; r++) begin
      pulseErrClr();
      done_force = (r == 6) ? 4'b0010 : 4'b0000;
      applyStimulus(vecs[r], k);
      drainScoreboard(200);
      @(negedge clkgen);
      done_force = '0;
      checkOutput($sformatf("v%0d_timeout_err", r), 64'(terr_a), 64'(vecs[r].exp_err));
      checkOutput($sformatf("v%0d_timeout_phase", r), 64'(tph_a), 64'(vecs[r].exp_tph));
      checkOutput($sformatf("v%0d_frame_count", r), 64'(fc_a), 64'(exp_fc_a));
      checkOutput($sformatf("v%0d_busy", r), 64'(a_if.busy), 64'd0);
      checkOutput($sformatf("v%0d_overrun", r), 64'(ovr_a), 64'd0);
      checkOutput($sformatf("v%0d_phase_active_hold", r), 64'(a_if.phase_active), 64'(NP - 1));
      pulseErrClr();
      #1;
      checkOutput($sformatf("v%0d_errclr_err", r), 64'(terr_a), 64'd0);
      checkOutput($sformatf("v%0d_errclr_phase", r), 64'(tph_a), 64'd0);
    end

    // Second vsync edge while busy: overrun, counted, still one frame_tick.
    ticks0 = tick_cnt_a;
    applyStimulus(mkVec(3, 3, 3, 3, 1'b0, 2'd0, 17), k);
    repeat (3) @(negedge clkgen);
    vsync_a = 1'b1;
    exp_fc_a++;
    @(negedge clkgen);
    vsync_a = 1'b0;
    drainScoreboard(200);
    repeat (5) @(negedge clkgen);
    checkOutput("ovr_overrun", 64'(ovr_a), 64'd1);
    checkOutput("ovr_frame_count", 64'(fc_a), 64'(exp_fc_a));
    checkOutput("ovr_tick_count", 64'(tick_cnt_a - ticks0), 64'd1);
    pulseErrClr();
    #1;
    checkOutput("ovr_cleared", 64'(ovr_a), 64'd0);

    // Reset during WAIT of phase 2 aborts at once; the next edge restarts at phase 0.
    applyStimulus(mkVec(3, 3, 10, 3, 1'b0, 2'd0, 24), k);
    repeat (10) @(negedge clkgen);
    checkOutput("prerst_busy", 64'(a_if.busy), 64'd1);
    checkOutput("prerst_phase_active", 64'(a_if.phase_active), 64'd2);
    #2;
    rst_n_a = 1'b0;
    #1;
    sb.delete();
    exp_fc_a = 0;
    checkOutput("midrst_phase_start", 64'(a_if.phase_start), 64'd0);
    checkOutput("midrst_busy", 64'(a_if.busy), 64'd0);
    checkOutput("midrst_phase_active", 64'(a_if.phase_active), 64'd0);
    checkOutput("midrst_frame_count", 64'(fc_a), 64'd0);
    checkOutput("midrst_frame_tick", 64'(a_if.frame_tick), 64'd0);
    repeat (2) @(negedge clkgen);
    rst_n_a = 1'b1;
    repeat (3) @(negedge clkgen);
    applyStimulus(mkVec(3, 3, 3, 3, 1'b0, 2'd0, 17), k);
    drainScoreboard(200);
    @(negedge clkgen);
    checkOutput("postrst_frame_count", 64'(fc_a), 64'd1);
    checkOutput("postrst_timeout_err", 64'(terr_a), 64'd0);

    // Divider table on B (FRAME_DIV=3): start on edges 1,4,7 of each run.
    for (int r = 0; r < 14; r++) begin
      if (dv[r].rst_first) begin
        @(negedge clkgen);
        rst_n_b = 1'b0;
        repeat (2) @(negedge clkgen);
        rst_n_b = 1'b1;
        exp_fc_b = 0;
        ticks0 = tick_cnt_b;
      end
      @(negedge clkgen);
      run_b = dv[r].run;
      vsync_b = 1'b1;
      exp_fc_b++;
      @(negedge clkgen);
      checkOutput($sformatf("div%0d_start0", r), 64'(b_if.phase_start[0]), 64'(dv[r].exp_seq));
      vsync_b = 1'b0;
      if (dv[r].exp_seq) ticks0++;
      repeat (12) @(negedge clkgen);
      checkOutput($sformatf("div%0d_frame_count", r), 64'(fc_b), 64'(exp_fc_b));
      checkOutput($sformatf("div%0d_ticks", r), 64'(tick_cnt_b), 64'(ticks0));
    end
    run_b = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
